if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC0_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter QDEPTH, default 2, SHALL set the instruction queue depth; only 2 is required.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 pc_in  in  32  SHALL carry the current PC from the PC register.
REQ-006 pc_next  out  32  SHALL be the PC register's next value (combinational).
REQ-007 imem_req  out  1  SHALL be the fetch request valid.
REQ-008 imem_addr  out  32  SHALL be the fetch address.
REQ-009 imem_gnt  in  1  SHALL signal request accepted.
REQ-010 imem_rvalid  in  1  SHALL signal read data valid.
REQ-011 imem_rdata  in  32  SHALL carry the instruction word.
REQ-012 redirect_valid  in  1  SHALL signal a branch/jump/exception redirect.
REQ-013 redirect_pc  in  32  SHALL carry the redirect target.
REQ-014 id_valid  out  1  SHALL flag a valid entry for decode.
REQ-015 id_ready  in  1  SHALL be decode's acceptance.
REQ-016 id_instr  out  32  SHALL carry the instruction, or 0 when id_adel=1.
REQ-017 id_pc  out  32  SHALL carry the PC of id_instr.
REQ-018 id_adel  out  1  SHALL flag a misaligned-fetch address error.

Function
REQ-019 FSM states SHALL be BOOT, REQ, WAIT and DROP.
REQ-020 BOOT: pc_next=RESET_PC; no request; next state REQ.
REQ-021 REQ: imem_req=1 SHALL assert iff (queue count + outstanding) < QDEPTH, pc_in[1:0]==0 and no redirect; imem_addr=pc_in.
REQ-022 REQ with imem_gnt=1: pc_next=pc_in+4 (mod 2^32, wrap permitted); next state WAIT; pc_in latched as the tag.
REQ-023 No grant and no redirect: pc_next SHALL equal pc_in (PC holds).
REQ-024 WAIT with imem_rvalid=1: push {tag, imem_rdata, adel=0}; next state REQ; rvalid in the same cycle as grant is illegal (minimum memory latency is 1 cycle).
REQ-025 Misaligned pc_in in REQ with a free slot: no request; push {pc_in, 0, adel=1}; then hold (pc_next=pc_in) until redirect.
REQ-026 A pushed entry SHALL appear on id_* in the next cycle (1-cycle registered latency rvalid→id_valid).
REQ-027 Pop SHALL occur on id_valid && id_ready; push and pop together at count 1 leave count at 1; overflow is impossible by REQ-021.
REQ-028 Redirect (any state): pc_next=redirect_pc; queue flushed so id_valid=0 next cycle; imem_req forced 0 that cycle.
REQ-029 Redirect while in WAIT, or coincident with imem_gnt: next state DROP; the pending response is discarded on rvalid, then REQ.
REQ-030 Redirect in DROP SHALL stay in DROP; in REQ or BOOT it SHALL go to REQ.
REQ-031 Redirect has priority over grant, push, pop and BOOT.

Reset
REQ-032 rst=1: state→BOOT, queue empty, outstanding=0, id_valid=0, imem_req=0, pc_next=RESET_PC, id_instr/id_pc/id_adel=0.
REQ-033 rst mid-fetch SHALL abandon the outstanding request; an imem_rvalid arriving in BOOT SHALL be ignored.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, the RESET_PC constant and the queue-entry layout (pc, instr, adel).
REQ-035 The queue SHALL be a sub-module if_queue (synchronous FIFO with flush, count output).

Verification
REQ-036 Reset then zero-wait memory, id_ready=1 → imem_addr BFC00000, BFC00004, BFC00008; id_pc follows in order, one instruction per 2 cycles.
REQ-037 id_ready=0 for 10 cycles → exactly 2 entries buffered, imem_req low, pc_next=pc_in; release → both drained in order.
REQ-038 Redirect to 80000180 during WAIT; stale rvalid 0x1234 arrives → discarded, next imem_addr 80000180, no 0x1234 on id_instr.
REQ-039 Redirect to 00400002 → id_valid with id_adel=1, id_pc=00400002, no imem_req until a new redirect.
REQ-040 rst pulsed while WAIT → BOOT, late rvalid ignored, fetch restarts at BFC00000.
REQ-041 pc_in=FFFFFFFC granted → pc_next=00000000.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM encoding, reset PC and
// the layout of one fetch-queue entry.
package if_fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam int          QDEPTH_DEFAULT   = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } fetch_entry_t;

  function automatic logic pc_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response side and the
// fetch-to-decode side.
interface if_fetch_if;

  // imem: a request transfers when imem_req && imem_gnt in the same cycle;
  // exactly one imem_rvalid follows at least one cycle later.
  // decode: an entry transfers when id_valid && id_ready; id_* hold stable
  // while id_valid && !id_ready.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_adel;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output id_valid, id_instr, id_pc, id_adel,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  id_valid, id_instr, id_pc, id_adel,
    output id_ready
  );

endinterface

// File: rtl/if_queue.sv
// Small synchronous FIFO of fetched entries with flush and occupancy count.
// The head is read straight from storage, so a push is visible next cycle.
module if_queue
  import if_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic          valid,
  output logic [CW-1:0] count
);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           full;
  logic           do_push;
  logic           do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: nothing reads it unless count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign valid = (count != '0);

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch unit: issues one imem read at a time, buffers responses
// for decode, and handles redirects, stale responses and misaligned PCs.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = QDEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  pc_in,
  output logic [31:0]  pc_next,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  if_fetch_if.master   bus,
  output fetch_state_e state
);

  localparam int CW = $clog2(QDEPTH + 1);

  fetch_state_e  state_d;
  logic [31:0]   tag;
  logic          adel_lock;
  logic          outstanding;
  logic          slot_free;
  logic          can_issue;
  logic          req;
  logic          granted;
  logic          adel_push;
  logic          push;
  logic          pop;
  fetch_entry_t  push_data;
  fetch_entry_t  q_head;
  logic          q_valid;
  logic [CW-1:0] q_count;

  assign outstanding = (state == ST_WAIT) || (state == ST_DROP);
  assign slot_free   = (32'(q_count) + 32'(outstanding)) < 32'(QDEPTH);
  assign can_issue   = (state == ST_REQ) && slot_free && !adel_lock && !redirect_valid && !rst;
  assign req         = can_issue && pc_aligned(pc_in[1:0]);
  assign adel_push   = can_issue && !pc_aligned(pc_in[1:0]);
  assign granted     = req && bus.imem_gnt;
  assign pop         = q_valid && bus.id_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_BOOT;
    else     state <= state_d;
  end

  // A response already returning in the redirect cycle leaves nothing to drop.
  always_comb begin
    state_d = state;
    if (redirect_valid) begin
      unique case (state)
        ST_BOOT: state_d = ST_REQ;
        ST_REQ:  state_d = bus.imem_gnt ? ST_DROP : ST_REQ;
        ST_WAIT: state_d = bus.imem_rvalid ? ST_REQ : ST_DROP;
        ST_DROP: state_d = bus.imem_rvalid ? ST_REQ : ST_DROP;
        default: state_d = ST_BOOT;
      endcase
    end else begin
      unique case (state)
        ST_BOOT: state_d = ST_REQ;
        ST_REQ:  state_d = granted ? ST_WAIT : ST_REQ;
        ST_WAIT: state_d = bus.imem_rvalid ? ST_REQ : ST_WAIT;
        ST_DROP: state_d = bus.imem_rvalid ? ST_REQ : ST_DROP;
        default: state_d = ST_BOOT;
      endcase
    end
  end

  always_comb begin
    bus.imem_req  = req;
    bus.imem_addr = pc_in;
    push          = 1'b0;
    push_data     = '{pc: pc_in, instr: 32'h0, adel: 1'b1};
    if (rst)                       pc_next = RESET_PC;
    else if (redirect_valid)       pc_next = redirect_pc;
    else if (state == ST_BOOT)     pc_next = RESET_PC;
    else if (granted)              pc_next = pc_in + 32'd4;
    else                           pc_next = pc_in;
    if (!redirect_valid && !rst) begin
      if (state == ST_WAIT && bus.imem_rvalid) begin
        push      = 1'b1;
        push_data = '{pc: tag, instr: bus.imem_rdata, adel: 1'b0};
      end else if (adel_push) begin
        push      = 1'b1;
      end
    end
  end

  // adel_lock parks the PC on a misaligned address until the next redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag       <= '0;
      adel_lock <= 1'b0;
    end else begin
      if (granted) tag <= pc_in;
      if (redirect_valid)  adel_lock <= 1'b0;
      else if (adel_push)  adel_lock <= 1'b1;
    end
  end

  if_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (q_head),
    .valid     (q_valid),
    .count     (q_count)
  );

  assign bus.id_valid = q_valid;
  assign bus.id_instr = q_valid ? q_head.instr : 32'h0;
  assign bus.id_pc    = q_valid ? q_head.pc    : 32'h0;
  assign bus.id_adel  = q_valid ? q_head.adel  : 1'b0;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: memory model, PC register emulation,
// decode-side scoreboard, a vector table and directed corner-case sequences.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam int W = 65;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] pc;
    logic        gnt;
    logic        exp_req;
    logic [31:0] exp_next;
    logic        exp_vld;
    logic        exp_adel;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  pc_in;
  logic [31:0]  pc_next;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  fetch_state_e state;
  logic         gnt_en;

  if_fetch_if bus();
  assign bus.imem_gnt = bus.imem_req & gnt_en;

  if_fetch #(.RESET_PC(32'hBFC0_0000), .QDEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .pc_next        (pc_next),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .state          (state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // scoreboard and model state
  logic [W-1:0] exp_q[$];
  logic [31:0]  addr_log[$];
  int           pop_cyc[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           n_pop    = 0;
  int           cyc      = 0;
  bit           seen_stale = 0;
  bit           follow   = 1;
  bit           mem_auto = 1;
  int           mem_lat  = 1;
  bit           pend_active = 0;
  bit           pend_stale  = 0;
  logic [31:0]  pend_addr;
  int           pend_cnt;
  vec_t         vecs[8];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0F0F_3C3C;
  endfunction

  function automatic logic [31:0] log_at(input int k);
    return (addr_log.size() > k) ? addr_log[k] : 32'hDEAD_BEEF;
  endfunction

  function automatic int pop_at(input int k);
    return (pop_cyc.size() > k) ? pop_cyc[k] : -1000;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check65(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One clock: monitor decode, log grants, advance PC register and memory.
  task automatic step();
    logic [31:0] nxt;
    logic [31:0] ga;
    logic        g;
    logic [W-1:0] e;
    #2;
    if (bus.id_valid && bus.id_ready) begin
      n_pop++;
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL id_unexpected: got pc %h instr %h, expected no entry", bus.id_pc, bus.id_instr);
      end else begin
        e = exp_q.pop_front();
        check65("id_entry", {bus.id_pc, bus.id_instr, bus.id_adel}, e);
      end
    end
    if (bus.id_valid && bus.id_instr == 32'h0000_1234) seen_stale = 1;
    nxt = pc_next;
    g   = bus.imem_req && bus.imem_gnt;
    ga  = bus.imem_addr;
    if (g) addr_log.push_back(ga);
    if (redirect_valid || rst) begin
      exp_q.delete();
      if (pend_active) pend_stale = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (follow) pc_in = nxt;
    if (mem_auto) begin
      bus.imem_rvalid = 1'b0;
      if (g) begin
        pend_active = 1;
        pend_stale  = 0;
        pend_addr   = ga;
        pend_cnt    = mem_lat;
      end
      if (pend_active) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          pend_active     = 0;
          bus.imem_rvalid = 1'b1;
          if (pend_stale) begin
            bus.imem_rdata = 32'h0000_1234;
          end else begin
            bus.imem_rdata = mem_word(pend_addr);
            exp_q.push_back({pend_addr, bus.imem_rdata, 1'b0});
          end
        end
      end
    end
  endtask

  task automatic wait_for(input fetch_state_e s, input string name);
    bit found = 0;
    for (int i = 0; i < 20; i++) begin
      if (state == s && !bus.imem_rvalid && (s != ST_REQ || !pend_active)) begin
        found = 1;
        break;
      end
      step();
    end
    n_checks++;
    if (found) n_pass++;
    else $display("FAIL %s: got no state %0d within 20 cycles, required it", name, s);
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    #1;
    check32("redir_req_low", 32'(bus.imem_req), 32'd0);
    check32("redir_pc_next", pc_next, target);
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int c0;
    vecs[0] = '{1'b0, 32'h0,         32'h0000_1000, 1'b1, 1'b1, 32'h0000_1004, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h0,         32'h0000_2000, 1'b0, 1'b1, 32'h0000_2000, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h0,         32'h0000_3001, 1'b1, 1'b0, 32'h0000_3001, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 32'h8000_0000, 32'h0000_4000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'h0,         32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h1234_5678, 32'h0000_5003, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 32'h0,         32'h0000_0010, 1'b1, 1'b1, 32'h0000_0014, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 32'h0,         32'h0000_7002, 1'b0, 1'b0, 32'h0000_7002, 1'b1, 1'b1};

    rst = 1'b1;
    pc_in = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    gnt_en = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.id_ready    = 1'b0;
    #1;

    // reset values
    step();
    step();
    #1;
    check32("rst_req",      32'(bus.imem_req), 32'd0);
    check32("rst_pc_next",  pc_next, 32'hBFC0_0000);
    check32("rst_id_valid", 32'(bus.id_valid), 32'd0);
    check32("rst_id_instr", bus.id_instr, 32'd0);
    check32("rst_id_pc",    bus.id_pc, 32'd0);
    check32("rst_id_adel",  32'(bus.id_adel), 32'd0);
    check32("rst_state",    32'(state), 32'(ST_BOOT));
    step();
    rst = 1'b0;
    gnt_en = 1'b1;
    bus.id_ready = 1'b1;
    addr_log.delete();
    pop_cyc.delete();
    c0 = cyc;

    // zero-wait streaming from the reset vector
    #1;
    check32("boot_state",   32'(state), 32'(ST_BOOT));
    check32("boot_req",     32'(bus.imem_req), 32'd0);
    check32("boot_pc_next", pc_next, 32'hBFC0_0000);
    repeat (8) step();
    check32("stream_addr0", log_at(0), 32'hBFC0_0000);
    check32("stream_addr1", log_at(1), 32'hBFC0_0004);
    check32("stream_addr2", log_at(2), 32'hBFC0_0008);
    check32("stream_first_pop", 32'(pop_at(0) - c0), 32'd3);
    check32("stream_gap1", 32'(pop_at(1) - pop_at(0)), 32'd2);
    check32("stream_gap2", 32'(pop_at(2) - pop_at(1)), 32'd2);

    // decode stall fills the queue, then drains in order
    bus.id_ready = 1'b0;
    repeat (10) step();
    check32("stall_id_valid", 32'(bus.id_valid), 32'd1);
    check32("stall_req",      32'(bus.imem_req), 32'd0);
    check32("stall_pc_hold",  pc_next, pc_in);
    check32("stall_pc_next",  pc_next, 32'hBFC0_0014);
    check32("stall_head_pc",  bus.id_pc, 32'hBFC0_000C);
    check32("stall_state",    32'(state), 32'(ST_REQ));
    gnt_en = 1'b0;
    bus.id_ready = 1'b1;
    n_pop = 0;
    repeat (3) step();
    check32("drain_count", 32'(n_pop), 32'd2);
    check32("drain_empty", 32'(bus.id_valid), 32'd0);

    // redirect during WAIT discards the stale response
    gnt_en = 1'b1;
    mem_lat = 3;
    wait_for(ST_WAIT, "wait_before_redirect");
    redirect_to(32'h8000_0180);
    #1;
    check32("drop_state", 32'(state), 32'(ST_DROP));
    addr_log.delete();
    seen_stale = 0;
    repeat (10) step();
    check32("drop_next_addr", log_at(0), 32'h8000_0180);
    check32("drop_no_stale",  32'(seen_stale), 32'd0);

    // misaligned redirect target raises an address error and parks
    wait_for(ST_REQ, "req_before_adel");
    redirect_to(32'h0040_0002);
    exp_q.push_back({32'h0040_0002, 32'h0, 1'b1});
    addr_log.delete();
    n_pop = 0;
    repeat (8) step();
    check32("adel_pops",     32'(n_pop), 32'd1);
    check32("adel_no_fetch", 32'(addr_log.size()), 32'd0);
    check32("adel_req",      32'(bus.imem_req), 32'd0);
    check32("adel_pc_hold",  pc_next, 32'h0040_0002);
    check32("adel_id_valid", 32'(bus.id_valid), 32'd0);
    redirect_to(32'h0000_1000);
    addr_log.delete();
    repeat (4) step();
    check32("adel_release_addr", log_at(0), 32'h0000_1000);

    // reset mid-fetch, late response lands in BOOT
    mem_lat = 2;
    wait_for(ST_WAIT, "wait_before_rst");
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check32("rst_mid_state", 32'(state), 32'(ST_BOOT));
    check32("rst_mid_req",   32'(bus.imem_req), 32'd0);
    check32("rst_mid_pc",    pc_next, 32'hBFC0_0000);
    addr_log.delete();
    seen_stale = 0;
    repeat (8) step();
    check32("rst_restart_addr", log_at(0), 32'hBFC0_0000);
    check32("rst_no_stale",     32'(seen_stale), 32'd0);

    // single-cycle vectors from a clean REQ state
    gnt_en = 1'b0;
    wait_for(ST_REQ, "req_before_table");
    bus.id_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    follow = 0;
    mem_auto = 0;
    bus.imem_rvalid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check32($sformatf("tbl%0d_state", i), 32'(state), 32'(ST_REQ));
      pc_in          = vecs[i].pc;
      gnt_en         = vecs[i].gnt;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      #1;
      check32($sformatf("tbl%0d_req", i), 32'(bus.imem_req), 32'(vecs[i].exp_req));
      check32($sformatf("tbl%0d_pc_next", i), pc_next, vecs[i].exp_next);
      step();
      redirect_valid  = 1'b0;
      gnt_en          = 1'b0;
      bus.imem_rvalid = vecs[i].exp_req & vecs[i].gnt;
      bus.imem_rdata  = 32'h0;
      #1;
      check32($sformatf("tbl%0d_id_valid", i), 32'(bus.id_valid), 32'(vecs[i].exp_vld));
      check32($sformatf("tbl%0d_id_adel", i), 32'(bus.id_adel), 32'(vecs[i].exp_adel));
      step();
      bus.imem_rvalid = 1'b0;
      redirect_valid  = 1'b1;
      redirect_pc     = 32'h0000_0100;
      step();
      redirect_valid  = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
